prg_loader: RTL and testbench
=============================

# prg_loader

Parametrised successor to the fixed PRG DMA path in the PET top level. Accepts the mist_io ioctl byte stream and decodes an optional little-endian load-address header. Buffers payload bytes in a small FIFO and writes them to a target memory through a valid/ack handshake that may stall. After the payload, it optionally patches the BASIC end-of-program pointer and reports the end address.

## Interface
Parameters:
- ADDR_W, 16: target address width.
- FIFO_DEPTH, 4: payload FIFO entries; power of two, at least 2.
- FILE_INDEX, 8'd2: ioctl_index value this block responds to.
- HDR_EN, 1: 1 means the first two bytes are the load address; 0 means raw load at RAW_BASE.
- RAW_BASE, 16'h0401: base address when HDR_EN=0.
- PTR_EN, 1: write end_addr to PTR_ADDR/PTR_ADDR+1 after the payload.
- PTR_ADDR, 16'h002A: pointer location (PET VARTAB).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  file index.
- ioctl_wr  in  1  byte strobe.
- ioctl_addr  in  25  byte offset within the file.
- ioctl_dout  in  8  byte data.
- ioctl_wait  out  1  backpressure to mist_io.
- mem_addr  out  ADDR_W  write address.
- mem_dout  out  8  write data.
- mem_we  out  1  write request (valid).
- mem_ack  in  1  write accepted (ready).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- end_addr  out  ADDR_W  last payload address + 1.
- err  out  1  sticky error; cleared at the next download start.

## Operation
- A byte is accepted on a cycle with ioctl_wr && ioctl_download && ioctl_index==FILE_INDEX.
- States: IDLE, HDR, DATA, DRAIN, PTR_LO, PTR_HI, DONE.
- IDLE: on a qualified ioctl_download rising edge, clear err, clear end_addr and the byte count, then go to HDR (HDR_EN=1) or DATA (HDR_EN=0, base=RAW_BASE).
- HDR: ioctl_addr 0 loads base[7:0]; ioctl_addr 1 loads base[15:8] and moves to DATA. Higher base bits are zero when ADDR_W>16.
- DATA: payload address = base + (ioctl_addr − 2·HDR_EN), computed in ADDR_W+1 bits.
  - Carry out of ADDR_W: byte dropped, err set.
  - Otherwise {addr, data} is pushed to the FIFO and end_addr becomes addr+1.
- ioctl_wait = FIFO full, or state ∉ {IDLE, HDR, DATA}. A byte arriving while the FIFO is full is dropped and sets err.
- Download falling edge from HDR: err set, go to DONE. mem_we never asserts.
- Download falling edge from DATA: go to DRAIN.
- DRAIN: wait for FIFO empty and no outstanding write. Then go to PTR_LO if PTR_EN && HDR_EN && at least one payload byte was written; otherwise go to DONE.
- PTR_LO writes end_addr[7:0] to PTR_ADDR. PTR_HI writes end_addr[15:8] to PTR_ADDR+1. Both use the same handshake as payload writes.
- DONE: done=1 for one cycle, then IDLE.
- A download start outside IDLE is ignored; ioctl_wait stays high.
- reset_n low at any point: state IDLE, FIFO empty, all outputs 0 (ioctl_wait 0). No partial write completes after reset.

## Timing
- FIFO head is registered. A byte accepted at cycle n can drive mem_we at n+1 at the earliest.
- Once mem_we rises, mem_addr/mem_dout stay stable until a cycle with mem_ack=1, which retires the entry.
- The next entry may be presented on the following cycle, giving back-to-back throughput of one byte per cycle with mem_ack tied high.
- FIFO push and pop in the same cycle are both legal; occupancy is unchanged.
- end_addr is valid from the cycle after the last payload accept and holds until the next download start.
- done is asserted the cycle after the final ack, or the cycle after the DRAIN exit condition holds when there are no pointer writes.

## Structure
- Package prg_loader_pkg holds:
  - the state enum;
  - default constants VARTAB_ADDR=16'h002A and PET_BASIC_BASE=16'h0401.
- Sub-module loader_fifo: synchronous FIFO, width ADDR_W+8, depth FIFO_DEPTH, full/empty flags, simultaneous push/pop supported, async active-low reset.

## Test plan
- Header file 01 04 AA BB CC, mem_ack tied 1 → writes 0401=AA, 0402=BB, 0403=CC, then 002A=04, 002B=04. end_addr=0404; done pulses once; err=0.
- Same file with mem_ack low for 10 cycles per write → ioctl_wait asserts once 4 entries are buffered. Write order is identical and no byte is lost.
- HDR_EN=0, 3 bytes → writes at 0401..0403, no pointer writes, done pulses.
- Header FF FF followed by 2 data bytes → write to FFFF performed, second byte dropped, err=1.
- Download ends after 1 byte → no mem_we, err=1, done pulses.
- reset_n asserted mid-DATA with a stalled write → mem_we=0, busy=0 immediately. A fresh download afterwards completes correctly.

Source files
------------

// File: rtl/prg_loader_pkg.sv
// Shared state encoding and PET memory-map defaults for the PRG loader.
package prg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_DRAIN,
        ST_PTR_LO,
        ST_PTR_HI,
        ST_DONE
    } state_e;

    localparam logic [15:0] VARTAB_ADDR    = 16'h002A;
    localparam logic [15:0] PET_BASIC_BASE = 16'h0401;

endpackage

// File: rtl/loader_fifo.sv
// Small synchronous FIFO; the head entry is read straight from the storage
// registers so a pushed entry is visible at the output one cycle later.
module loader_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // NOTE: storage is not reset; only the pointers are, and an empty FIFO never exposes stale data.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: rtl/prg_loader.sv
// ioctl PRG download loader: decodes the load-address header, buffers payload
// bytes and writes them to target memory, then patches the BASIC end pointer.
module prg_loader
    import prg_loader_pkg::*;
#(
    parameter int          ADDR_W     = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  FILE_INDEX = 8'd2,
    parameter bit          HDR_EN     = 1'b1,
    parameter logic [15:0] RAW_BASE   = PET_BASIC_BASE,
    parameter bit          PTR_EN     = 1'b1,
    parameter logic [15:0] PTR_ADDR   = VARTAB_ADDR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dout,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] end_addr,
    output logic              err
);

    localparam int             DW      = ADDR_W + 8;
    localparam int             SW      = 26;
    localparam logic [SW-1:0]  HDR_OFS = HDR_EN ? SW'(2) : '0;

    state_e            state_q;
    logic [ADDR_W-1:0] base_q, end_q;
    logic              err_q, any_q, dl_q;

    logic              accept, start, fall, carry, push, pop;
    logic              fifo_full, fifo_empty;
    logic [SW-1:0]     sum;
    logic [ADDR_W-1:0] pay_addr;
    logic [DW-1:0]     head;

    // Offsets beyond the address space (including any ioctl_addr bits above it) count as carry.
    always_comb begin
        accept   = ioctl_wr && ioctl_download && (ioctl_index == FILE_INDEX);
        start    = ioctl_download && !dl_q && (ioctl_index == FILE_INDEX);
        fall     = !ioctl_download && dl_q;
        sum      = SW'(base_q) + SW'(ioctl_addr) - HDR_OFS;
        carry    = |sum[SW-1:ADDR_W];
        pay_addr = sum[ADDR_W-1:0];
        push     = (state_q == ST_DATA) && accept && !carry && !fifo_full;
        pop      = !fifo_empty && mem_ack;
    end

    loader_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .data_i  ({pay_addr, ioctl_dout}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_dout = '0;
        if (state_q == ST_PTR_LO) begin
            mem_we   = 1'b1;
            mem_addr = ADDR_W'(PTR_ADDR);
            mem_dout = end_q[7:0];
        end else if (state_q == ST_PTR_HI) begin
            mem_we   = 1'b1;
            mem_addr = ADDR_W'(PTR_ADDR + 16'd1);
            mem_dout = end_q[15:8];
        end else if (!fifo_empty) begin
            mem_we   = 1'b1;
            mem_addr = head[DW-1:8];
            mem_dout = head[7:0];
        end
    end

    assign ioctl_wait = fifo_full || !(state_q inside {ST_IDLE, ST_HDR, ST_DATA});
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign end_addr   = end_q;
    assign err        = err_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            end_q   <= '0;
            err_q   <= 1'b0;
            any_q   <= 1'b0;
            dl_q    <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            unique case (state_q)
                ST_IDLE: if (start) begin
                    err_q   <= 1'b0;
                    end_q   <= '0;
                    any_q   <= 1'b0;
                    base_q  <= HDR_EN ? '0 : ADDR_W'(RAW_BASE);
                    state_q <= HDR_EN ? ST_HDR : ST_DATA;
                end
                ST_HDR: if (fall) begin
                    err_q   <= 1'b1;
                    state_q <= ST_DONE;
                end else if (accept && ioctl_addr == 25'd0) begin
                    base_q <= ADDR_W'(ioctl_dout);
                end else if (accept && ioctl_addr == 25'd1) begin
                    base_q[15:8] <= ioctl_dout;
                    state_q      <= ST_DATA;
                end
                ST_DATA: if (fall) begin
                    state_q <= ST_DRAIN;
                end else if (accept) begin
                    if (carry || fifo_full) begin
                        err_q <= 1'b1;
                    end else begin
                        end_q <= pay_addr + ADDR_W'(1);
                        any_q <= 1'b1;
                    end
                end
                ST_DRAIN: if (fifo_empty) begin
                    state_q <= (PTR_EN && HDR_EN && any_q) ? ST_PTR_LO : ST_DONE;
                end
                ST_PTR_LO: if (mem_ack) state_q <= ST_PTR_HI;
                ST_PTR_HI: if (mem_ack) state_q <= ST_DONE;
                ST_DONE:   state_q <= ST_IDLE;
                default:   state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: directed and random downloads compared
// against a list-of-writes reference model built from the file contents.
module tb_prg_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr, mem_ack;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;

    logic        ioctl_wait, mem_we, busy, done, err;
    logic [15:0] mem_addr, end_addr;
    logic [7:0]  mem_dout;
    logic        r_ioctl_wait, r_mem_we, r_busy, r_done, r_err;
    logic [15:0] r_mem_addr, r_end_addr;
    logic [7:0]  r_mem_dout;

    int checks = 0;
    int errors = 0;
    int ack_mode = 3;
    int stall_cnt = 0;
    int cyc = 0, done_cnt = 0, rdone_cnt = 0, done_cyc = 0, last_ack_cyc = 0, we_cnt = 0;
    logic        prev_hold = 1'b0;
    logic [23:0] prev_wd;
    logic [23:0] got_q[$], rgot_q[$], exp_q[$];
    logic [7:0]  file_q[$];

    always #5 clk = ~clk;

    prg_loader dut (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we), .mem_ack(mem_ack),
        .busy(busy), .done(done), .end_addr(end_addr), .err(err)
    );

    prg_loader #(.HDR_EN(1'b0), .FILE_INDEX(8'd3)) dut_raw (
        .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(r_ioctl_wait),
        .mem_addr(r_mem_addr), .mem_dout(r_mem_dout), .mem_we(r_mem_we), .mem_ack(mem_ack),
        .busy(r_busy), .done(r_done), .end_addr(r_end_addr), .err(r_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory-side responder: 0 = always ready, 1 = 10 stall cycles per write, 2 = random, 3 = never.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ack_mode)
                0: mem_ack = 1'b1;
                1: begin
                    if (mem_we || r_mem_we) begin
                        mem_ack = (stall_cnt == 10);
                        stall_cnt = mem_ack ? 0 : stall_cnt + 1;
                    end else begin
                        mem_ack = 1'b0;
                        stall_cnt = 0;
                    end
                end
                2: mem_ack = 1'($urandom_range(0, 1));
                default: mem_ack = 1'b0;
            endcase
        end
    end

    // Monitor: records completed handshakes and checks that a stalled write holds steady.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (prev_hold) check("hold", {7'd0, mem_we, mem_addr, mem_dout}, {7'd0, 1'b1, prev_wd});
            if (mem_we) we_cnt++;
            if (mem_we && mem_ack) begin
                got_q.push_back({mem_addr, mem_dout});
                last_ack_cyc = cyc;
            end
            if (r_mem_we && mem_ack) rgot_q.push_back({r_mem_addr, r_mem_dout});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (r_done) rdone_cnt++;
            prev_hold = mem_we && !mem_ack;
            prev_wd   = {mem_addr, mem_dout};
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic run_test(input string name, input bit raw, input int mode, input bit chk_occ);
        int          n, h, acc, d0, base, a;
        bit          e_err, any, saw;
        logic [15:0] e_end;
        n = file_q.size();
        h = raw ? 0 : 2;
        // Reference: each payload byte lands at base + its payload index; out-of-range bytes are dropped.
        exp_q.delete();
        e_err = 1'b0; e_end = '0; any = 1'b0;
        if (n < h) begin
            e_err = 1'b1;
        end else begin
            base = raw ? 32'h0401 : {16'd0, file_q[1], file_q[0]};
            for (int i = h; i < n; i++) begin
                a = base + (i - h);
                if (a > 32'hFFFF) e_err = 1'b1;
                else begin
                    exp_q.push_back({a[15:0], file_q[i]});
                    e_end = 16'(a + 1);
                    any = 1'b1;
                end
            end
            if (!raw && any) begin
                exp_q.push_back({16'h002A, e_end[7:0]});
                exp_q.push_back({16'h002B, e_end[15:8]});
            end
        end

        got_q.delete(); rgot_q.delete(); we_cnt = 0;
        d0 = raw ? rdone_cnt : done_cnt;
        ack_mode = mode;
        @(posedge clk); #1;
        ioctl_index = raw ? 8'd3 : 8'd2;
        ioctl_download = 1'b1;
        @(posedge clk); #1;
        acc = 0; saw = 1'b0;
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while ((raw ? r_ioctl_wait : ioctl_wait) && g < 2000) begin
                ioctl_wr = 1'b0;
                if (chk_occ && !saw && i >= h) begin
                    saw = 1'b1;
                    check({name, "/occ"}, 32'(acc - got_q.size()), 32'd4);
                end
                @(posedge clk); #1;
                g++;
            end
            if (g >= 2000) check({name, "/wait_timeout"}, 32'(g), 32'd0);
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = file_q[i];
            @(posedge clk); #1;
            if (i >= h) acc++;
        end
        ioctl_wr = 1'b0;
        @(posedge clk); #1;
        ioctl_download = 1'b0;

        for (int g = 0; g < 3000 && (raw ? rdone_cnt : done_cnt) == d0; g++) @(negedge clk);
        repeat (4) @(negedge clk);

        check({name, "/done_cnt"}, 32'((raw ? rdone_cnt : done_cnt) - d0), 32'd1);
        if (raw) begin
            check({name, "/nwr"}, 32'(rgot_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < rgot_q.size(); i++)
                check({name, "/wr"}, 32'(rgot_q[i]), 32'(exp_q[i]));
            check({name, "/err"}, 32'(r_err), 32'(e_err));
            check({name, "/end"}, 32'(r_end_addr), 32'(e_end));
            check({name, "/idle"}, {30'd0, r_busy, r_ioctl_wait}, 32'd0);
        end else begin
            check({name, "/nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
                check({name, "/wr"}, 32'(got_q[i]), 32'(exp_q[i]));
            check({name, "/err"}, 32'(err), 32'(e_err));
            check({name, "/end"}, 32'(end_addr), 32'(e_end));
            check({name, "/idle"}, {30'd0, busy, ioctl_wait}, 32'd0);
            if (any) check({name, "/done_lat"}, 32'(done_cyc), 32'(last_ack_cyc + 1));
            if (exp_q.size() == 0) check({name, "/no_we"}, 32'(we_cnt), 32'd0);
            if (chk_occ) check({name, "/wait_seen"}, 32'(saw), 32'd1);
        end
    endtask

    initial begin
        logic [15:0] b;
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) @(posedge clk); #1;
        check("rst/outs", {12'd0, mem_we, busy, done, err, ioctl_wait, mem_addr[10:0], end_addr[3:0]}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst/after", {16'd0, end_addr}, 32'd0);
        check("rst/flags", {27'd0, mem_we, busy, done, err, ioctl_wait}, 32'd0);

        file_q = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        run_test("basic", 1'b0, 0, 1'b0);
        run_test("basic_stall", 1'b0, 1, 1'b0);

        file_q = '{8'h01, 8'h04};
        for (int i = 0; i < 7; i++) file_q.push_back(8'($urandom));
        run_test("long_stall", 1'b0, 1, 1'b1);

        file_q = '{8'h11, 8'h22, 8'h33};
        run_test("raw3", 1'b1, 0, 1'b0);

        file_q = '{8'hFF, 8'hFF, 8'h5A, 8'hA5};
        run_test("top_carry", 1'b0, 0, 1'b0);

        file_q = '{8'h01};
        run_test("short", 1'b0, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            b = ($urandom_range(0, 3) == 0) ? 16'hFFFA : 16'($urandom);
            file_q = '{b[7:0], b[15:8]};
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) file_q.push_back(8'($urandom));
            run_test("rand_hdr", 1'b0, int'($urandom_range(0, 2)), 1'b0);
        end
        for (int t = 0; t < 2; t++) begin
            file_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++) file_q.push_back(8'($urandom));
            run_test("rand_raw", 1'b1, int'($urandom_range(0, 2)), 1'b0);
        end

        // Reset while a payload write is stalled.
        ack_mode = 3;
        @(posedge clk); #1;
        ioctl_index = 8'd2; ioctl_download = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(8'h50 + i);
            @(posedge clk); #1;
        end
        ioctl_wr = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_mid/pre_we", {31'd0, mem_we}, 32'd1);
        reset_n = 1'b0; ioctl_download = 1'b0;
        #1;
        check("rst_mid/we_busy", {30'd0, mem_we, busy}, 32'd0);
        check("rst_mid/outs", {10'd0, done, err, ioctl_wait, mem_addr[12:0], end_addr[5:0]}, 32'd0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        file_q = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
        run_test("after_rst", 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
